dps_utim64_arbiter: RTL and testbench

- Two-master arbiter sharing one dps_utim64 register port between requester A (CPU DPS bus) and requester B (debug/DMA agent).
- Round-robin grant, one outstanding read at a time, read data routed back to the issuing master.
- Sits between the DPS bus fabric and the dps_utim64 instance, in the iCLOCK domain.
- Device bus convention: REQ_RW=0 read, REQ_RW=1 write; ADDR 5 bits; DATA 32 bits.

---
 rtl/dps_utim64_arb_pkg.sv | 20 ++
 rtl/dps_utim64_arb_rr.sv | 25 ++
 rtl/dps_utim64_arbiter.sv | 142 ++++++++++++++
 tb/tb_dps_utim64_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dps_utim64_arb_pkg.sv
// Shared encodings for the dps_utim64 two-master arbiter: FSM states, owner ids, RW codes.
package dps_utim64_arb_pkg;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_READ_WAIT = 1'b1
  } state_t;

  // Owner ids double as the priority encoding (prio == id of the favoured master).
  localparam logic OWN_A    = 1'b0;
  localparam logic OWN_B    = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic logic is_write(input logic rw);
    return rw == RW_WRITE;
  endfunction

endpackage

// File: rtl/dps_utim64_arb_rr.sv
// Two-way round-robin grant: one-hot grant from the request vector and the prio bit.
// On accept the winner drops to lowest priority; otherwise the prio bit is held.
module dps_utim64_arb_rr
  import dps_utim64_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_next_prio
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_prio == OWN_B) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  assign o_next_prio = i_accept ? (o_gnt[0] ? OWN_B : OWN_A) : i_prio;

endmodule

// File: rtl/dps_utim64_arbiter.sv
// Round-robin arbiter sharing one dps_utim64 register port between masters A and B.
// Read-abort timeout is built only when DPS_UTIM64_ARB_TIMEOUT_EN is defined.
module dps_utim64_arbiter
  import dps_utim64_arb_pkg::*;
#(
  parameter int          P_TIMEOUT  = 255,
  parameter logic [31:0] P_ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iMA_REQ_VALID,
  output logic        oMA_REQ_BUSY,
  input  logic        iMA_REQ_RW,
  input  logic [4:0]  iMA_REQ_ADDR,
  input  logic [31:0] iMA_REQ_DATA,
  output logic        oMA_REQ_VALID,
  output logic [31:0] oMA_REQ_DATA,
  input  logic        iMB_REQ_VALID,
  output logic        oMB_REQ_BUSY,
  input  logic        iMB_REQ_RW,
  input  logic [4:0]  iMB_REQ_ADDR,
  input  logic [31:0] iMB_REQ_DATA,
  output logic        oMB_REQ_VALID,
  output logic [31:0] oMB_REQ_DATA,
  output logic        oDEV_REQ_VALID,
  input  logic        iDEV_REQ_BUSY,
  output logic        oDEV_REQ_RW,
  output logic [4:0]  oDEV_REQ_ADDR,
  output logic [31:0] oDEV_REQ_DATA,
  input  logic        iDEV_REQ_VALID,
  input  logic [31:0] iDEV_REQ_DATA,
  output logic        oERR_TIMEOUT
);

  if ((P_TIMEOUT < 1) || (P_TIMEOUT > 65535)) begin : g_bad_timeout
    $error("P_TIMEOUT must be within 1..65535");
  end

  state_t      r_state;
  logic        r_owner;
  logic        r_prio;

  logic        w_idle;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_accept;
  logic        w_acc_rd;
  logic        w_next_prio;
  logic        w_rsp;
  logic        w_tmo;
  logic        w_done;
  logic [31:0] w_rdat;

  assign w_idle = (r_state == ST_IDLE);
  // A busy device blocks the grant itself, so prio cannot move while it is busy.
  assign w_req  = (w_idle && !iDEV_REQ_BUSY) ? {iMB_REQ_VALID, iMA_REQ_VALID} : 2'b00;

  dps_utim64_arb_rr u_rr (
    .i_req       (w_req),
    .i_prio      (r_prio),
    .i_accept    (w_accept),
    .o_gnt       (w_gnt),
    .o_next_prio (w_next_prio)
  );

  assign w_accept       = |w_gnt;
  assign oDEV_REQ_VALID = w_accept;

  always_comb begin
    oDEV_REQ_RW   = RW_READ;
    oDEV_REQ_ADDR = '0;
    oDEV_REQ_DATA = '0;
    if (w_gnt[0]) begin
      oDEV_REQ_RW   = iMA_REQ_RW;
      oDEV_REQ_ADDR = iMA_REQ_ADDR;
      oDEV_REQ_DATA = iMA_REQ_DATA;
    end else if (w_gnt[1]) begin
      oDEV_REQ_RW   = iMB_REQ_RW;
      oDEV_REQ_ADDR = iMB_REQ_ADDR;
      oDEV_REQ_DATA = iMB_REQ_DATA;
    end
  end

  assign w_acc_rd     = w_accept && !is_write(oDEV_REQ_RW);
  assign oMA_REQ_BUSY = !w_idle || iDEV_REQ_BUSY || w_gnt[1];
  assign oMB_REQ_BUSY = !w_idle || iDEV_REQ_BUSY || w_gnt[0];

  // Responses only count while waiting; anything arriving in IDLE is dropped.
  assign w_rsp  = !w_idle && iDEV_REQ_VALID;
  assign w_done = w_rsp || w_tmo;
  assign w_rdat = w_rsp ? iDEV_REQ_DATA : P_ERR_DATA;

  assign oMA_REQ_VALID = w_done && (r_owner == OWN_A);
  assign oMB_REQ_VALID = w_done && (r_owner == OWN_B);
  assign oMA_REQ_DATA  = oMA_REQ_VALID ? w_rdat : '0;
  assign oMB_REQ_DATA  = oMB_REQ_VALID ? w_rdat : '0;
  assign oERR_TIMEOUT  = w_tmo;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_A;
      r_prio  <= OWN_A;
    end else begin
      r_prio <= w_next_prio;
      case (r_state)
        ST_IDLE: begin
          if (w_acc_rd) begin
            r_state <= ST_READ_WAIT;
            r_owner <= w_gnt[1] ? OWN_B : OWN_A;
          end
        end
        ST_READ_WAIT: begin
          if (w_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DPS_UTIM64_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TMO_LAST = 16'(P_TIMEOUT - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_cnt <= '0;
    end else if (w_acc_rd) begin
      r_cnt <= '0;
    end else if (!w_idle) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // A device response in the same cycle takes precedence over the abort.
  assign w_tmo = !w_idle && !iDEV_REQ_VALID && (r_cnt == LP_TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_dps_utim64_arbiter.sv
// Scoreboard bench for dps_utim64_arbiter: directed scenarios then randomized traffic.
module tb_dps_utim64_arbiter;

  localparam int          TB_TMO  = 4;
  localparam logic [31:0] ERR_DAT = 32'hFFFF_FFFF;
`ifdef DPS_UTIM64_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        iCLOCK, iRESET;
  logic        iMA_REQ_VALID, oMA_REQ_BUSY, iMA_REQ_RW, oMA_REQ_VALID;
  logic [4:0]  iMA_REQ_ADDR;
  logic [31:0] iMA_REQ_DATA, oMA_REQ_DATA;
  logic        iMB_REQ_VALID, oMB_REQ_BUSY, iMB_REQ_RW, oMB_REQ_VALID;
  logic [4:0]  iMB_REQ_ADDR;
  logic [31:0] iMB_REQ_DATA, oMB_REQ_DATA;
  logic        oDEV_REQ_VALID, iDEV_REQ_BUSY, oDEV_REQ_RW, iDEV_REQ_VALID, oERR_TIMEOUT;
  logic [4:0]  oDEV_REQ_ADDR;
  logic [31:0] oDEV_REQ_DATA, iDEV_REQ_DATA;

  dps_utim64_arbiter #(.P_TIMEOUT(TB_TMO), .P_ERR_DATA(ERR_DAT)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iMA_REQ_VALID(iMA_REQ_VALID), .oMA_REQ_BUSY(oMA_REQ_BUSY), .iMA_REQ_RW(iMA_REQ_RW),
    .iMA_REQ_ADDR(iMA_REQ_ADDR), .iMA_REQ_DATA(iMA_REQ_DATA),
    .oMA_REQ_VALID(oMA_REQ_VALID), .oMA_REQ_DATA(oMA_REQ_DATA),
    .iMB_REQ_VALID(iMB_REQ_VALID), .oMB_REQ_BUSY(oMB_REQ_BUSY), .iMB_REQ_RW(iMB_REQ_RW),
    .iMB_REQ_ADDR(iMB_REQ_ADDR), .iMB_REQ_DATA(iMB_REQ_DATA),
    .oMB_REQ_VALID(oMB_REQ_VALID), .oMB_REQ_DATA(oMB_REQ_DATA),
    .oDEV_REQ_VALID(oDEV_REQ_VALID), .iDEV_REQ_BUSY(iDEV_REQ_BUSY), .oDEV_REQ_RW(oDEV_REQ_RW),
    .oDEV_REQ_ADDR(oDEV_REQ_ADDR), .oDEV_REQ_DATA(oDEV_REQ_DATA),
    .iDEV_REQ_VALID(iDEV_REQ_VALID), .iDEV_REQ_DATA(iDEV_REQ_DATA),
    .oERR_TIMEOUT(oERR_TIMEOUT)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed { logic rw; logic [4:0] addr; logic [31:0] dat; } req_t;
  typedef struct packed { logic [31:0] dat; logic tmo; } rsp_t;
  typedef struct packed { logic busy_a; logic busy_b; logic dev; logic va; logic vb; logic err; } cyc_t;

  req_t exp_dev_q[$];
  rsp_t exp_a_q[$];
  rsp_t exp_b_q[$];
  cyc_t exp_cyc_q[$];

  int total = 0;
  int bad   = 0;
  int obs_lo = 0;
  int obs_hi = 0;

  // Reference model: who is waiting, who owns the read, who is favoured next.
  bit          m_wait, m_owner, m_prio_b;
  int          m_waited;
  logic [31:0] mem [32];
  bit          rd_pending;
  int          rd_cd;
  logic [31:0] rd_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: DUT output present but nothing expected", nm);
  endtask

  function automatic req_t mk(input logic rw, input logic [4:0] a, input logic [31:0] d);
    req_t r;
    r.rw = rw; r.addr = a; r.dat = d;
    return r;
  endfunction

  task automatic zero_inputs();
    iMA_REQ_VALID = 0; iMA_REQ_RW = 0; iMA_REQ_ADDR = '0; iMA_REQ_DATA = '0;
    iMB_REQ_VALID = 0; iMB_REQ_RW = 0; iMB_REQ_ADDR = '0; iMB_REQ_DATA = '0;
    iDEV_REQ_BUSY = 0; iDEV_REQ_VALID = 0; iDEV_REQ_DATA = '0;
  endtask

  task automatic drive_cycle(input bit va, input req_t ra, input bit vb, input req_t rb,
                             input bit dbusy, input bit dvld, input logic [31:0] ddat,
                             output bit acc_a, output bit acc_b);
    cyc_t c;
    rsp_t p;
    req_t r;
    int   w;
    @(posedge iCLOCK); #1;
    iMA_REQ_VALID = va; iMA_REQ_RW = ra.rw; iMA_REQ_ADDR = ra.addr; iMA_REQ_DATA = ra.dat;
    iMB_REQ_VALID = vb; iMB_REQ_RW = rb.rw; iMB_REQ_ADDR = rb.addr; iMB_REQ_DATA = rb.dat;
    iDEV_REQ_BUSY = dbusy; iDEV_REQ_VALID = dvld; iDEV_REQ_DATA = ddat;
    acc_a = 0; acc_b = 0;
    c = '0; c.busy_a = 1; c.busy_b = 1;
    if (m_wait) begin
      m_waited++;
      if (dvld || (TMO_ON && m_waited == TB_TMO)) begin
        p.dat = dvld ? ddat : ERR_DAT;
        p.tmo = !dvld;
        if (m_owner) begin exp_b_q.push_back(p); c.vb = 1; end
        else begin exp_a_q.push_back(p); c.va = 1; end
        c.err  = !dvld;
        m_wait = 0;
      end
    end else begin
      w = -1;
      if (!dbusy) begin
        if (va && vb) w = m_prio_b ? 1 : 0;
        else if (va)  w = 0;
        else if (vb)  w = 1;
      end
      c.busy_a = dbusy || (w == 1);
      c.busy_b = dbusy || (w == 0);
      if (w >= 0) begin
        r = (w == 1) ? rb : ra;
        exp_dev_q.push_back(r);
        c.dev    = 1;
        m_prio_b = (w == 0);
        acc_a    = (w == 0);
        acc_b    = (w == 1);
        if (r.rw) mem[r.addr] = r.dat;
        else begin
          m_wait = 1; m_owner = (w == 1); m_waited = 0;
          rd_pending = 1; rd_cd = $urandom_range(0, TMO_ON ? 5 : 3); rd_data = mem[r.addr];
        end
      end
    end
    exp_cyc_q.push_back(c);
  endtask

  task automatic idle_cycle(input bit dvld, input logic [31:0] ddat);
    bit aa, ab;
    drive_cycle(0, mk(0, 0, 0), 0, mk(0, 0, 0), 0, dvld, ddat, aa, ab);
  endtask

  task automatic do_reset();
    @(posedge iCLOCK); #1;
    iRESET = 1;
    zero_inputs();
    m_wait = 0; m_prio_b = 0; rd_pending = 0;
    repeat (2) @(posedge iCLOCK);
    #1 iRESET = 0;
  endtask

  // Monitor: per-cycle expectations plus transaction queues popped when the DUT presents data.
  initial begin : monitor
    cyc_t c;
    req_t r;
    rsp_t p;
    forever begin
      @(negedge iCLOCK);
      if (exp_cyc_q.size() != 0) begin
        c = exp_cyc_q.pop_front();
        chk("busy_a", oMA_REQ_BUSY, c.busy_a);
        chk("busy_b", oMB_REQ_BUSY, c.busy_b);
        chk("dev_valid", oDEV_REQ_VALID, c.dev);
        chk("a_valid", oMA_REQ_VALID, c.va);
        chk("b_valid", oMB_REQ_VALID, c.vb);
        chk("err_timeout", oERR_TIMEOUT, c.err);
        if (oDEV_REQ_VALID) begin
          if (oDEV_REQ_ADDR[4]) obs_hi++; else obs_lo++;
          if (exp_dev_q.size() == 0) unexpected("dev_req");
          else begin
            r = exp_dev_q.pop_front();
            chk("dev_req_fields", {oDEV_REQ_RW, oDEV_REQ_ADDR, oDEV_REQ_DATA}, r);
          end
        end else begin
          chk("dev_fields_no_grant", {oDEV_REQ_RW, oDEV_REQ_ADDR, oDEV_REQ_DATA}, '0);
          if (c.dev && exp_dev_q.size() != 0) void'(exp_dev_q.pop_front());
        end
        if (oMA_REQ_VALID) begin
          if (exp_a_q.size() == 0) unexpected("a_rsp");
          else begin p = exp_a_q.pop_front(); chk("a_rsp", {oMA_REQ_DATA, oERR_TIMEOUT}, p); end
        end else begin
          chk("a_data_idle", oMA_REQ_DATA, '0);
          if (c.va && exp_a_q.size() != 0) void'(exp_a_q.pop_front());
        end
        if (oMB_REQ_VALID) begin
          if (exp_b_q.size() == 0) unexpected("b_rsp");
          else begin p = exp_b_q.pop_front(); chk("b_rsp", {oMB_REQ_DATA, oERR_TIMEOUT}, p); end
        end else begin
          chk("b_data_idle", oMB_REQ_DATA, '0);
          if (c.vb && exp_b_q.size() != 0) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    bit   aa, ab, pa, pb, dv, dbz;
    req_t qa, qb;
    logic [31:0] dd;
    int   lo0, hi0;

    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    iRESET = 1;
    zero_inputs();
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    chk("rst_busy_a", oMA_REQ_BUSY, 0);
    chk("rst_busy_b", oMB_REQ_BUSY, 0);
    chk("rst_dev_valid", oDEV_REQ_VALID, 0);
    chk("rst_dev_fields", {oDEV_REQ_RW, oDEV_REQ_ADDR, oDEV_REQ_DATA}, '0);
    chk("rst_a_out", {oMA_REQ_VALID, oMA_REQ_DATA}, '0);
    chk("rst_b_out", {oMB_REQ_VALID, oMB_REQ_DATA}, '0);
    chk("rst_err", oERR_TIMEOUT, 0);
    @(posedge iCLOCK); #1 iRESET = 0;

    // Simultaneous reads: A first, then B, each response routed only to its issuer.
    drive_cycle(1, mk(0, 5'h00, 0), 1, mk(0, 5'h10, 0), 0, 0, 0, aa, ab);
    repeat (2) drive_cycle(0, mk(0, 0, 0), 1, mk(0, 5'h10, 0), 0, 0, 0, aa, ab);
    drive_cycle(0, mk(0, 0, 0), 1, mk(0, 5'h10, 0), 0, 1, 32'h0000_AAAA, aa, ab);
    drive_cycle(0, mk(0, 0, 0), 1, mk(0, 5'h10, 0), 0, 0, 0, aa, ab);
    repeat (2) idle_cycle(0, 0);
    idle_cycle(1, 32'h0000_BBBB);

    // Fairness: both masters stream writes for 8 cycles.
    @(negedge iCLOCK); #1;
    lo0 = obs_lo; hi0 = obs_hi;
    for (int i = 0; i < 8; i++)
      drive_cycle(1, mk(1, 5'h01, 32'hA000_0000 + i), 1, mk(1, 5'h11, 32'hB000_0000 + i), 0, 0, 0, aa, ab);
    @(negedge iCLOCK); #1;
    chk("fair_grants_a", obs_lo - lo0, 4);
    chk("fair_grants_b", obs_hi - hi0, 4);

    // Single write from A, then a contended cycle must favour B.
    drive_cycle(1, mk(1, 5'h02, 32'h0000_1234), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);
    drive_cycle(1, mk(1, 5'h03, 32'h3), 1, mk(1, 5'h13, 32'h13), 0, 0, 0, aa, ab);
    drive_cycle(1, mk(1, 5'h03, 32'h3), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);

    // Device busy for 5 cycles blocks A; accepted when busy drops.
    repeat (5) drive_cycle(1, mk(1, 5'h05, 32'h5555), 0, mk(0, 0, 0), 1, 0, 0, aa, ab);
    drive_cycle(1, mk(1, 5'h05, 32'h5555), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);

    // Reset during B's read, then a late response that must be dropped.
    drive_cycle(0, mk(0, 0, 0), 1, mk(0, 5'h12, 0), 0, 0, 0, aa, ab);
    repeat (2) idle_cycle(0, 0);
    do_reset();
    idle_cycle(1, 32'hDEAD_BEEF);
    drive_cycle(1, mk(1, 5'h06, 32'h6666), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);

`ifdef DPS_UTIM64_ARB_TIMEOUT_EN
    // Read with no device response aborts on the 4th wait cycle.
    drive_cycle(1, mk(0, 5'h07, 0), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);
    repeat (4) idle_cycle(0, 0);
    drive_cycle(1, mk(1, 5'h08, 32'h8888), 0, mk(0, 0, 0), 0, 0, 0, aa, ab);
`endif

    // Randomized traffic with a latency-modelled device and occasional stray responses.
    rd_pending = 0;
    pa = 0; pb = 0; qa = '0; qb = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1; qa = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1; qb = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      end
      dbz = ($urandom_range(0, 7) == 0);
      dv  = 0;
      dd  = $urandom;
      if (rd_pending) begin
        if (rd_cd == 0) begin dv = 1; dd = rd_data; rd_pending = 0; end
        else rd_cd--;
      end else if ($urandom_range(0, 29) == 0) begin
        dv = 1;
      end
      drive_cycle(pa, qa, pb, qb, dbz, dv, dd, aa, ab);
      if (aa) pa = 0;
      if (ab) pb = 0;
    end
    repeat (3) idle_cycle(0, 0);
    @(negedge iCLOCK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
